video_pattern_scheduler: RTL and testbench
==========================================

Name: video_pattern_scheduler

Overview:
Controller that sequences the test-pattern datapath (colour-bar and other pattern generators) feeding the HDMI encoder.
- Holds host-written configuration in shadow registers.
- Applies configuration only at frame boundaries, so there is no mid-frame tearing.
- Either holds one pattern (manual, with single-step) or auto-cycles patterns every DWELL frames.
- Drives the generator enable and pattern-select mux.

Parameters:
NUM_PATTERNS, 8, number of selectable patterns (2..8); pattern_sel wraps at NUM_PATTERNS-1.
DWELL_W, 8, width of dwell register and frame counter.
DEFAULT_DWELL, 60, dwell reset value in frames (about 1 s at 60 Hz).

Ports:
clk  in  1  pixel clock, the only clock.
rst  in  1  synchronous, active-high reset.
frame_start  in  1  one-cycle pulse at pixel (0,0) from the timing generator.
cfg_we  in  1  register write strobe.
cfg_addr  in  2  register address: 0=CTRL, 1=DWELL, 2=PATTERN, 3=STATUS (read-only).
cfg_wdata  in  8  write data.
cfg_rdata  out  8  registered read data for cfg_addr.
cfg_ack  out  1  write acknowledge.
pattern_sel  out  3  pattern index to the generator mux.
pattern_enable  out  1  generator enable; 0 forces black.
pattern_changed  out  1  one-cycle pulse when pattern_sel or pattern_enable changes.

Behaviour:
- Reset, on the clk edge with rst=1:
  - State OFF.
  - Outputs: pattern_sel=0, pattern_enable=0, cfg_ack=0, cfg_rdata=0, pattern_changed=0.
  - Shadow registers: en_sh=0, auto_sh=0, step_pend=0, pat_sh=0, dwell_sh=DEFAULT_DWELL, dwell_cnt=0.
  - Reset mid-frame takes effect immediately; any pending step is discarded.
- CTRL register: bit0 = en, bit1 = auto, bit2 = step (write-1 sets step_pend; bit2 reads back step_pend).
- Writes:
  - Update shadow registers on the cfg_we cycle.
  - cfg_ack is high exactly one cycle after each cfg_we; back-to-back writes produce back-to-back acks.
- PATTERN write with value >= NUM_PATTERNS: ignored, pat_sh unchanged, still acked.
- cfg_rdata: registered, 1-cycle latency.
  - Addr 0 reads {5'b0, step_pend, auto_sh, en_sh}.
  - Addr 1 reads dwell_sh.
  - Addr 2 reads pat_sh.
  - Addr 3 reads {3'b0, state[1:0], pattern_sel}.
- States: OFF(0), MANUAL(1), AUTO(2). Transitions are evaluated only on a frame_start cycle, using shadow values as they stood before any write in that same cycle.
  - !en_sh -> OFF. pattern_enable=0; pattern_sel holds its value; step_pend cleared.
  - en_sh & !auto_sh -> MANUAL. pattern_enable=1.
    - If step_pend: pattern_sel = pat_sh+1 (wraps to 0 past NUM_PATTERNS-1); pat_sh is updated to the same value; step_pend cleared.
    - Else: pattern_sel = pat_sh.
  - en_sh & auto_sh -> AUTO. pattern_enable=1; step_pend cleared (ignored).
    - On entry from OFF or MANUAL: pattern_sel = pat_sh, dwell_cnt=0.
    - While staying in AUTO, each frame_start:
      - If dwell_cnt >= max(dwell_sh,1)-1: pattern_sel increments with wrap, dwell_cnt=0.
      - Else: dwell_cnt increments.
    - dwell_sh=0 behaves as 1, so the pattern advances every frame.
    - A DWELL write while running applies from the next compare. If the new dwell_sh <= dwell_cnt+1, the pattern advances at the next frame_start.
- Outside frame_start cycles, state, pattern_sel and pattern_enable never change (except under reset).
- pattern_changed is asserted in the cycle after the frame_start that altered pattern_sel or pattern_enable.
- Latency: the write cycle followed by the first frame_start produces new outputs on the clock edge of that frame_start.

Decomposition:
- Package video_pattern_pkg holds:
  - State encoding constants (OFF/MANUAL/AUTO).
  - Register address constants.
  - CTRL bit positions.
  - Wrap-increment function for pattern indices.
- One natural sub-module, frame_dwell_counter: counts frame_start pulses against dwell_sh, emits an advance pulse, and takes a clear input.

Test Plan:
- Reset then 3 frame_starts, no writes -> pattern_enable=0, pattern_sel=0, cfg_rdata(addr3)=0x00, no pattern_changed.
- Write PATTERN=5, then CTRL=0x01 mid-frame -> outputs unchanged until the next frame_start, then pattern_sel=5, pattern_enable=1, pattern_changed pulses once; cfg_ack seen 1 cycle after each write.
- MANUAL at pattern 7, write CTRL=0x05 -> at the next frame_start pattern_sel=0 (wrap), PATTERN reads 0, CTRL bit2 reads 0.
- Write DWELL=2, CTRL=0x03 with pat_sh=6 -> over 7 frame_starts, pattern_sel = 6,6,7,7,0,0,1 (one value per frame_start in order).
- Write DWELL=0 in AUTO -> pattern_sel advances on every frame_start; a PATTERN write of 9 is acked and readback stays unchanged.
- Assert rst during AUTO with step_pend=1 -> next cycle OFF, pattern_sel=0, DWELL reads 60, CTRL reads 0x00.

Source files
------------

// File: rtl/video_pattern_pkg.sv
// Shared encodings and helpers for the test-pattern scheduler.
package video_pattern_pkg;

   typedef enum logic [1:0] {
      StOff    = 2'd0,
      StManual = 2'd1,
      StAuto   = 2'd2
   } state_e;

   localparam logic [1:0] AddrCtrl    = 2'd0;
   localparam logic [1:0] AddrDwell   = 2'd1;
   localparam logic [1:0] AddrPattern = 2'd2;
   localparam logic [1:0] AddrStatus  = 2'd3;

   localparam int unsigned CtrlEnBit   = 0;
   localparam int unsigned CtrlAutoBit = 1;
   localparam int unsigned CtrlStepBit = 2;

   function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int unsigned num);
      if (32'(idx) >= num - 1) return 3'd0;
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/frame_dwell_counter.sv
// Counts frames against the dwell setting and flags when the pattern should advance.
module frame_dwell_counter #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_i,
   input  logic               clear_i,
   input  logic [DWELL_W-1:0] dwell_i,
   output logic               advance_o
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] limit;

   // A dwell of zero behaves like one: advance on every tick.
   assign limit     = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
   assign advance_o = tick_i && (cnt_q >= limit);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         cnt_q <= '0;
      end else if (tick_i) begin
         cnt_q <= advance_o ? '0 : cnt_q + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/video_pattern_scheduler.sv
// Frame-synchronous test-pattern sequencer with host-visible shadow registers.
module video_pattern_scheduler
   import video_pattern_pkg::*;
#(
   parameter int unsigned NUM_PATTERNS  = 8,
   parameter int unsigned DWELL_W       = 8,
   parameter int unsigned DEFAULT_DWELL = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_wdata,
   output logic [7:0] cfg_rdata,
   output logic       cfg_ack,
   output logic [2:0] pattern_sel,
   output logic       pattern_enable,
   output logic       pattern_changed
);

   state_e             state_q, state_d;
   logic               en_sh_q, auto_sh_q, step_pend_q;
   logic [2:0]         pat_sh_q;
   logic [DWELL_W-1:0] dwell_sh_q;
   logic [2:0]         sel_d;
   logic               en_d, step_clr, pat_step, stay_auto, advance;

   assign stay_auto = frame_start && en_sh_q && auto_sh_q && (state_q == StAuto);

   frame_dwell_counter #(
      .DWELL_W (DWELL_W)
   ) u_dwell (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (stay_auto),
      .clear_i   (frame_start && !stay_auto),
      .dwell_i   (dwell_sh_q),
      .advance_o (advance)
   );

   // Decisions use shadow values as registered, before any same-cycle write.
   always_comb begin
      state_d  = state_q;
      sel_d    = pattern_sel;
      en_d     = pattern_enable;
      step_clr = 1'b0;
      pat_step = 1'b0;
      if (frame_start) begin
         if (!en_sh_q) begin
            state_d  = StOff;
            en_d     = 1'b0;
            step_clr = 1'b1;
         end else if (!auto_sh_q) begin
            state_d = StManual;
            en_d    = 1'b1;
            if (step_pend_q) begin
               sel_d    = wrap_inc(pat_sh_q, NUM_PATTERNS);
               pat_step = 1'b1;
               step_clr = 1'b1;
            end else begin
               sel_d = pat_sh_q;
            end
         end else begin
            state_d  = StAuto;
            en_d     = 1'b1;
            step_clr = 1'b1;
            if (state_q != StAuto) begin
               sel_d = pat_sh_q;
            end else if (advance) begin
               sel_d = wrap_inc(pattern_sel, NUM_PATTERNS);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StOff;
         pattern_sel     <= 3'd0;
         pattern_enable  <= 1'b0;
         pattern_changed <= 1'b0;
         cfg_ack         <= 1'b0;
         cfg_rdata       <= 8'd0;
         en_sh_q         <= 1'b0;
         auto_sh_q       <= 1'b0;
         step_pend_q     <= 1'b0;
         pat_sh_q        <= 3'd0;
         dwell_sh_q      <= DWELL_W'(DEFAULT_DWELL);
      end else begin
         state_q         <= state_d;
         pattern_sel     <= sel_d;
         pattern_enable  <= en_d;
         pattern_changed <= frame_start && ((sel_d != pattern_sel) || (en_d != pattern_enable));
         cfg_ack         <= cfg_we;
         case (cfg_addr)
            AddrCtrl:    cfg_rdata <= {5'b0, step_pend_q, auto_sh_q, en_sh_q};
            AddrDwell:   cfg_rdata <= 8'(dwell_sh_q);
            AddrPattern: cfg_rdata <= {5'b0, pat_sh_q};
            AddrStatus:  cfg_rdata <= {3'b0, state_q, pattern_sel};
            default:     cfg_rdata <= 8'd0;
         endcase
         if (step_clr) step_pend_q <= 1'b0;
         if (pat_step) pat_sh_q <= sel_d;
         // Host writes land after the frame update so they win on collision.
         if (cfg_we) begin
            case (cfg_addr)
               AddrCtrl: begin
                  en_sh_q   <= cfg_wdata[CtrlEnBit];
                  auto_sh_q <= cfg_wdata[CtrlAutoBit];
                  if (cfg_wdata[CtrlStepBit]) step_pend_q <= 1'b1;
               end
               AddrDwell: dwell_sh_q <= DWELL_W'(cfg_wdata);
               AddrPattern: begin
                  if (32'(cfg_wdata) < NUM_PATTERNS) pat_sh_q <= cfg_wdata[2:0];
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Scoreboard bench: drivers queue expected reads and frame results, a monitor checks them.
module tb_video_pattern_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = 2'd0;
   logic [7:0] cfg_wdata = 8'd0;
   logic [7:0] cfg_rdata;
   logic       cfg_ack;
   logic [2:0] pattern_sel;
   logic       pattern_enable;
   logic       pattern_changed;
   logic       rd_req = 1'b0;

   logic       we_d = 1'b0, rd_d = 1'b0, fs_d = 1'b0, rst_d = 1'b0;

   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
   } rd_exp_t;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic       chg;
   } frame_exp_t;

   rd_exp_t    rd_q[$];
   frame_exp_t frame_q[$];
   int         checks = 0;
   int         errors = 0;

   video_pattern_scheduler dut (
      .clk             (clk),
      .rst             (rst),
      .frame_start     (frame_start),
      .cfg_we          (cfg_we),
      .cfg_addr        (cfg_addr),
      .cfg_wdata       (cfg_wdata),
      .cfg_rdata       (cfg_rdata),
      .cfg_ack         (cfg_ack),
      .pattern_sel     (pattern_sel),
      .pattern_enable  (pattern_enable),
      .pattern_changed (pattern_changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      we_d  <= cfg_we;
      rd_d  <= rd_req;
      fs_d  <= frame_start;
      rst_d <= rst;
   end

   always @(negedge clk) begin
      rd_exp_t    r;
      frame_exp_t f;
      if (rst_d) begin
         checks = checks + 1;
         if (pattern_sel !== 3'd0 || pattern_enable !== 1'b0 || cfg_ack !== 1'b0 ||
             cfg_rdata !== 8'd0 || pattern_changed !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: got sel=%0d en=%b ack=%b rdata=%h chg=%b, want all zero",
                     pattern_sel, pattern_enable, cfg_ack, cfg_rdata, pattern_changed);
         end
      end else begin
         if (we_d || cfg_ack) begin
            checks = checks + 1;
            if (cfg_ack !== we_d) begin
               errors = errors + 1;
               $display("FAIL cfg_ack: got %b want %b", cfg_ack, we_d);
            end
         end
         if (rd_d) begin
            checks = checks + 1;
            if (rd_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL read_underflow: got rdata=%h with no expected entry", cfg_rdata);
            end else begin
               r = rd_q.pop_front();
               if (cfg_rdata !== r.data) begin
                  errors = errors + 1;
                  $display("FAIL read_addr%0d: got %h want %h", r.addr, cfg_rdata, r.data);
               end
            end
         end
         if (fs_d) begin
            checks = checks + 1;
            if (frame_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL frame_underflow: got sel=%0d with no expected entry", pattern_sel);
            end else begin
               f = frame_q.pop_front();
               if (pattern_sel !== f.sel || pattern_enable !== f.en || pattern_changed !== f.chg) begin
                  errors = errors + 1;
                  $display("FAIL frame: got sel=%0d en=%b chg=%b want sel=%0d en=%b chg=%b",
                           pattern_sel, pattern_enable, pattern_changed, f.sel, f.en, f.chg);
               end
            end
         end else if (pattern_changed !== 1'b0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL spurious_changed: got %b want 0", pattern_changed);
         end
      end
   end

   task automatic drive(input logic we, input logic [1:0] addr, input logic [7:0] data,
                        input logic fs, input logic rd);
      cfg_we      = we;
      cfg_addr    = addr;
      cfg_wdata   = data;
      frame_start = fs;
      rd_req      = rd;
      @(posedge clk);
      #1;
      cfg_we      = 1'b0;
      cfg_addr    = 2'd0;
      cfg_wdata   = 8'd0;
      frame_start = 1'b0;
      rd_req      = 1'b0;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [7:0] data);
      drive(1'b1, addr, data, 1'b0, 1'b0);
   endtask

   task automatic rd(input logic [1:0] addr, input logic [7:0] exp);
      rd_q.push_back('{addr: addr, data: exp});
      drive(1'b0, addr, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic frame(input logic [2:0] sel, input logic en, input logic chg);
      frame_q.push_back('{sel: sel, en: en, chg: chg});
      drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle after reset: nothing enabled, no change pulses.
      rd(2'd3, 8'h00);
      rd(2'd0, 8'h00);
      rd(2'd1, 8'd60);
      rd(2'd2, 8'h00);
      for (int i = 0; i < 3; i++) frame(3'd0, 1'b0, 1'b0);
      rd(2'd3, 8'h00);

      // Manual enable applies only at the frame boundary.
      wr(2'd2, 8'd5);
      wr(2'd0, 8'h01);
      rd(2'd3, 8'h00);
      rd(2'd2, 8'h05);
      rd(2'd0, 8'h01);
      frame(3'd5, 1'b1, 1'b1);
      rd(2'd3, 8'h0D);
      frame(3'd5, 1'b1, 1'b0);

      // Single step wraps from the last pattern to zero.
      wr(2'd2, 8'd7);
      frame(3'd7, 1'b1, 1'b1);
      wr(2'd0, 8'h05);
      rd(2'd0, 8'h05);
      frame(3'd0, 1'b1, 1'b1);
      rd(2'd2, 8'h00);
      rd(2'd0, 8'h01);
      rd(2'd3, 8'h08);

      // Auto cycling with dwell 2 starting at pattern 6.
      wr(2'd2, 8'd6);
      wr(2'd1, 8'd2);
      wr(2'd0, 8'h03);
      frame(3'd6, 1'b1, 1'b1);
      frame(3'd6, 1'b1, 1'b0);
      frame(3'd7, 1'b1, 1'b1);
      frame(3'd7, 1'b1, 1'b0);
      frame(3'd0, 1'b1, 1'b1);
      frame(3'd0, 1'b1, 1'b0);
      frame(3'd1, 1'b1, 1'b1);
      rd(2'd3, 8'h11);

      // Dwell 0 advances every frame; out-of-range pattern write is ignored.
      wr(2'd1, 8'd0);
      frame(3'd2, 1'b1, 1'b1);
      frame(3'd3, 1'b1, 1'b1);
      frame(3'd4, 1'b1, 1'b1);
      wr(2'd2, 8'd9);
      rd(2'd2, 8'h06);
      frame(3'd5, 1'b1, 1'b1);
      wr(2'd0, 8'h07);
      rd(2'd0, 8'h07);

      // Reset during auto with a pending step.
      pulse_reset();
      rd(2'd3, 8'h00);
      rd(2'd1, 8'd60);
      rd(2'd0, 8'h00);
      rd(2'd2, 8'h00);
      frame(3'd0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checks = checks + 1;
      if (rd_q.size() != 0 || frame_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d reads and %0d frames outstanding, want 0 and 0",
                  rd_q.size(), frame_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
